// File: rtl/spi_pkg.sv
// Shared constants and master FSM encoding for the SPI master/slave pair.
package spi_pkg;

  localparam logic [7:0]  ACK_BYTE   = 8'h10;
  localparam int unsigned DATA_W     = 4;
  localparam int unsigned FRAME_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    HOLD,
    GAP
  } spi_mst_state_e;

endpackage

// File: rtl/spi_phase_timer.sv
// Loadable down-counter; o_tc is high while the count sits at zero.
module spi_phase_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic             o_tc
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - WIDTH'(1);
    end
  end

  assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/spi_master_module.sv
// SPI mode-0 master: one 4-bit nibble out, one 8-bit acknowledge byte in per ss_n frame.
// Define SPI_MASTER_ACK_CHECK_EN to build the acknowledge-byte comparator driving ack_error.
module spi_master_module
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned SS_GAP  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [7:0]        rx_ack,
  output logic              rx_valid,
  output logic              ack_error,
  output logic              busy,
  output logic              sclk_out,
  output logic              mosi_out,
  output logic              ss_n_out,
  input  logic              miso_in
);

  localparam int unsigned TIMER_MAX = (CLK_DIV > SS_GAP) ? CLK_DIV : SS_GAP;
  localparam int unsigned TIMER_W   = $clog2(TIMER_MAX) + 1;

  spi_mst_state_e r_state, w_state_next;

  logic                  w_tc, w_load;
  logic [TIMER_W-1:0]    w_load_val;
  logic                  w_accept, w_capture, w_sclk_fall, w_last_bit, w_frame_end, w_gap_end;
  logic                  r_sclk, r_mosi, r_ss_n, r_busy, r_rx_valid;
  logic                  r_miso_meta, r_miso_sync;
  logic [FRAME_BITS-1:0] r_tx_sr, r_rx_sr, r_rx_ack;
  logic [3:0]            r_bit_cnt;

  // Every phase change restarts the timer with the length of the phase being entered.
  assign w_load     = (w_state_next != r_state);
  assign w_load_val = (w_state_next == GAP) ? TIMER_W'(SS_GAP - 1) : TIMER_W'(CLK_DIV - 1);

  spi_phase_timer #(
    .WIDTH (TIMER_W)
  ) u_phase_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_tc       (w_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_state_next = SETUP;
      SETUP:   if (w_tc) w_state_next = HIGH;
      HIGH:    if (w_tc) w_state_next = w_last_bit ? HOLD : LOW;
      LOW:     if (w_tc) w_state_next = HIGH;
      HOLD:    if (w_tc) w_state_next = GAP;
      GAP:     if (w_tc) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    tx_ready    = (r_state == IDLE);
    w_accept    = tx_valid && (r_state == IDLE);
    w_capture   = w_tc && ((r_state == SETUP) || (r_state == LOW));
    w_sclk_fall = w_tc && (r_state == HIGH);
    w_last_bit  = (r_bit_cnt == 4'(FRAME_BITS));
    w_frame_end = w_tc && (r_state == HOLD);
    w_gap_end   = w_tc && (r_state == GAP);
  end

  // miso_in comes from another board device, so it is treated as asynchronous.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_miso_meta <= 1'b0;
      r_miso_sync <= 1'b0;
    end else begin
      r_miso_meta <= miso_in;
      r_miso_sync <= r_miso_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sclk     <= 1'b0;
      r_mosi     <= 1'b0;
      r_ss_n     <= 1'b1;
      r_busy     <= 1'b0;
      r_rx_valid <= 1'b0;
      r_tx_sr    <= '0;
      r_rx_sr    <= '0;
      r_rx_ack   <= '0;
      r_bit_cnt  <= '0;
    end else begin
      r_rx_valid <= 1'b0;
      if (w_accept) begin
        r_tx_sr   <= {tx_data, {(FRAME_BITS - DATA_W){1'b0}}};
        r_mosi    <= tx_data[DATA_W-1];
        r_ss_n    <= 1'b0;
        r_busy    <= 1'b1;
        r_rx_sr   <= '0;
        r_bit_cnt <= '0;
      end
      if (w_capture) begin
        r_sclk  <= 1'b1;
        r_rx_sr <= {r_rx_sr[FRAME_BITS-2:0], r_miso_sync};
        if (!w_last_bit) r_bit_cnt <= r_bit_cnt + 4'd1;
      end
      if (w_sclk_fall) begin
        r_sclk <= 1'b0;
        if (!w_last_bit) begin
          r_tx_sr <= {r_tx_sr[FRAME_BITS-2:0], 1'b0};
          r_mosi  <= r_tx_sr[FRAME_BITS-2];
        end
      end
      if (w_frame_end) begin
        r_ss_n     <= 1'b1;
        r_mosi     <= 1'b0;
        r_rx_ack   <= r_rx_sr;
        r_rx_valid <= 1'b1;
      end
      if (w_gap_end) r_busy <= 1'b0;
    end
  end

`ifdef SPI_MASTER_ACK_CHECK_EN
  logic r_ack_error;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ack_error <= 1'b0;
    end else if (w_frame_end) begin
      r_ack_error <= (r_rx_sr != ACK_BYTE);
    end
  end

  assign ack_error = r_ack_error;
`else
  assign ack_error = 1'b0;
`endif

  assign sclk_out = r_sclk;
  assign mosi_out = r_mosi;
  assign ss_n_out = r_ss_n;
  assign busy     = r_busy;
  assign rx_valid = r_rx_valid;
  assign rx_ack   = r_rx_ack;

endmodule

// File: tb/tb_spi_master_module.sv
// Bench for spi_master_module with a behavioural mode-0 slave and an SCLK/MOSI/ss_n monitor.
module tb_spi_master_module;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned SS_GAP  = 4;
  localparam int unsigned T_LOW   = 17 * CLK_DIV;
  localparam int unsigned T_RV    = T_LOW + 1;
  localparam int unsigned T_RDY   = T_LOW + 1 + SS_GAP;
  localparam logic [7:0]  GOOD_ACK = 8'h10;
`ifdef SPI_MASTER_ACK_CHECK_EN
  localparam bit ACK_CHK = 1'b1;
`else
  localparam bit ACK_CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] tx_data = 4'h0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, rx_valid, ack_error, busy, sclk_out, mosi_out, ss_n_out;
  logic [7:0] rx_ack;
  logic       miso_in = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  spi_master_module #(
    .CLK_DIV (CLK_DIV),
    .SS_GAP  (SS_GAP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_ack    (rx_ack),
    .rx_valid  (rx_valid),
    .ack_error (ack_error),
    .busy      (busy),
    .sclk_out  (sclk_out),
    .mosi_out  (mosi_out),
    .ss_n_out  (ss_n_out),
    .miso_in   (miso_in)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural slave: returns slave_ack MSB first, latches the nibble on SCLK edge 4.
  logic [7:0] slave_ack = GOOD_ACK;
  logic [7:0] s_tx = 8'h00;
  logic [2:0] s_rx = 3'h0;
  logic       s_sclk_q = 1'b0;
  int         s_bits = 0;
  logic [3:0] nib_q[$];

  always @(posedge clk) begin
    s_sclk_q <= sclk_out;
    if (ss_n_out !== 1'b0) begin
      s_bits  <= 0;
      s_tx    <= slave_ack;
      miso_in <= slave_ack[7];
    end else if (sclk_out && !s_sclk_q) begin
      if (s_bits < 3) s_rx <= {s_rx[1:0], mosi_out};
      if (s_bits == 3) nib_q.push_back({s_rx, mosi_out});
      s_bits <= s_bits + 1;
    end else if (!sclk_out && s_sclk_q) begin
      s_tx    <= {s_tx[6:0], 1'b0};
      miso_in <= s_tx[6];
    end
  end

  // Monitor: per-frame SCLK edge count, half-period and MOSI stability, ss_n run lengths.
  logic m_sclk_p = 1'b0, m_mosi_p = 1'b0, m_ssn_p = 1'b1;
  int m_age = 0, m_half = 0, m_rises = 0, m_bad_half = 0, m_bad_mosi = 0;
  int m_ssn_run = 0, m_low_len = 0, m_gap_len = 0;
  int rv_cnt = 0, rv_cyc = 0;
  logic [7:0] rv_ack = 8'h00;
  logic rv_err = 1'b0;

  always @(negedge clk) begin
    automatic int age_prev = m_age;
    if (ss_n_out !== m_ssn_p) begin
      if (ss_n_out === 1'b0) begin
        m_gap_len = m_ssn_run; m_rises = 0; m_bad_half = 0; m_bad_mosi = 0;
      end else begin
        m_low_len = m_ssn_run;
      end
      m_ssn_run = 1;
    end else begin
      m_ssn_run++;
    end
    m_age = (mosi_out !== m_mosi_p) ? 1 : m_age + 1;
    if (sclk_out !== m_sclk_p) begin
      if (sclk_out === 1'b1) begin
        m_rises++;
        if (m_age < CLK_DIV + 1) m_bad_mosi++;
        if (m_rises > 1 && m_half != CLK_DIV) m_bad_half++;
      end else begin
        if (m_half != CLK_DIV) m_bad_half++;
        if (age_prev < 2 * CLK_DIV) m_bad_mosi++;
      end
      m_half = 1;
    end else begin
      m_half++;
    end
    if (rx_valid === 1'b1) begin
      rv_cnt++; rv_cyc = cyc; rv_ack = rx_ack; rv_err = ack_error;
    end
    m_sclk_p = sclk_out; m_mosi_p = mosi_out; m_ssn_p = ss_n_out;
  end

  function automatic logic model_err(input logic [7:0] ack);
    return ACK_CHK && (ack != GOOD_ACK);
  endfunction

  task automatic wait_ready();
    int k = 0;
    @(negedge clk);
    while (tx_ready !== 1'b1 && k < 300) begin @(negedge clk); k++; end
  endtask

  task automatic send_frame(input logic [3:0] nib, input logic [7:0] ack, input string tag);
    int t, n0, k;
    logic [3:0] got;
    logic want_err;
    want_err = model_err(ack);
    slave_ack = ack;
    wait_ready();
    t = cyc; n0 = rv_cnt;
    tx_data = nib; tx_valid = 1'b1;
    @(negedge clk); tx_valid = 1'b0;
    k = 0;
    while (rv_cnt == n0 && k < 300) begin @(negedge clk); k++; end
    @(negedge clk);
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++; $display("FAIL %s rx_valid_pulse: got %b want 0", tag, rx_valid);
    end
    checks++;
    if (rv_cnt !== n0 + 1 || rv_cyc !== t + T_RV) begin
      errors++;
      $display("FAIL %s rx_valid_time: got count %0d at t+%0d want 1 at t+%0d",
               tag, rv_cnt - n0, rv_cyc - t, T_RV);
    end
    checks++;
    if (rv_ack !== ack) begin
      errors++; $display("FAIL %s rx_ack: got %h want %h", tag, rv_ack, ack);
    end
    checks++;
    if (rv_err !== want_err) begin
      errors++; $display("FAIL %s ack_error: got %b want %b", tag, rv_err, want_err);
    end
    k = 0;
    while (tx_ready !== 1'b1 && k < 300) begin @(negedge clk); k++; end
    checks++;
    if (cyc !== t + T_RDY) begin
      errors++; $display("FAIL %s tx_ready_time: got t+%0d want t+%0d", tag, cyc - t, T_RDY);
    end
    checks++;
    if (ack_error !== want_err || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s held_state: got ack_error %b busy %b want %b 0", tag, ack_error, busy,
               want_err);
    end
    checks++;
    if (m_rises !== 8 || m_bad_half !== 0 || m_bad_mosi !== 0) begin
      errors++;
      $display("FAIL %s sclk_shape: got rises %0d bad_half %0d bad_mosi %0d want 8 0 0",
               tag, m_rises, m_bad_half, m_bad_mosi);
    end
    checks++;
    if (m_low_len !== T_LOW) begin
      errors++; $display("FAIL %s ss_n_low: got %0d want %0d", tag, m_low_len, T_LOW);
    end
    got = 4'hx;
    if (nib_q.size() != 0) got = nib_q.pop_front();
    checks++;
    if (got !== nib || nib_q.size() != 0) begin
      errors++; $display("FAIL %s slave_nibble: got %h want %h", tag, got, nib);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({sclk_out, mosi_out, ss_n_out, rx_valid, ack_error, busy} !== 6'b001000 ||
        rx_ack !== 8'h00) begin
      errors++;
      $display("FAIL reset_values: got sclk %b mosi %b ss_n %b rxv %b err %b busy %b ack %h",
               sclk_out, mosi_out, ss_n_out, rx_valid, ack_error, busy, rx_ack);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_ready !== 1'b1 || busy !== 1'b0 || ss_n_out !== 1'b1) begin
      errors++;
      $display("FAIL after_reset: got ready %b busy %b ss_n %b want 1 0 1", tx_ready, busy,
               ss_n_out);
    end
  endtask

  task automatic test_basic();
    send_frame(4'hA, GOOD_ACK, "basic_A");
  endtask

  task automatic test_back_to_back();
    int t1, t2, n0, k;
    logic [3:0] g1, g2;
    slave_ack = GOOD_ACK;
    wait_ready();
    t1 = cyc; n0 = rv_cnt;
    tx_data = 4'h3; tx_valid = 1'b1;
    @(negedge clk); tx_data = 4'hC;
    k = 0;
    while (tx_ready !== 1'b1 && k < 300) begin @(negedge clk); k++; end
    t2 = cyc;
    @(negedge clk); tx_valid = 1'b0;
    k = 0;
    while (tx_ready !== 1'b1 && k < 300) begin @(negedge clk); k++; end
    checks++;
    if (t2 !== t1 + T_RDY) begin
      errors++; $display("FAIL b2b_second_accept: got t+%0d want t+%0d", t2 - t1, T_RDY);
    end
    // Gap between frames is the GAP phase plus the IDLE cycle in which the accept happens.
    checks++;
    if (m_gap_len !== SS_GAP + 1) begin
      errors++; $display("FAIL b2b_ss_gap: got %0d want %0d", m_gap_len, SS_GAP + 1);
    end
    checks++;
    if (rv_cnt !== n0 + 2 || rv_cyc !== t2 + T_RV || rv_ack !== GOOD_ACK) begin
      errors++;
      $display("FAIL b2b_rx: got count %0d at t2+%0d ack %h want 2 at t2+%0d ack %h",
               rv_cnt - n0, rv_cyc - t2, rv_ack, T_RV, GOOD_ACK);
    end
    g1 = 4'hx; g2 = 4'hx;
    if (nib_q.size() != 0) g1 = nib_q.pop_front();
    if (nib_q.size() != 0) g2 = nib_q.pop_front();
    checks++;
    if (g1 !== 4'h3 || g2 !== 4'hC) begin
      errors++; $display("FAIL b2b_nibbles: got %h %h want 3 c", g1, g2);
    end
  endtask

  task automatic test_ignore_busy();
    int t, n0, bad;
    logic [3:0] nib, got;
    nib = 4'($urandom_range(15, 0));
    slave_ack = GOOD_ACK;
    wait_ready();
    t = cyc; n0 = rv_cnt; bad = 0;
    tx_data = nib; tx_valid = 1'b1;
    @(negedge clk);
    while (cyc < t + T_RDY) begin
      if (busy !== 1'b1 || tx_ready !== 1'b0) bad++;
      tx_valid = (cyc == t + 20);
      if (cyc == t + 20) tx_data = ~nib;
      @(negedge clk);
    end
    tx_valid = 1'b0;
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL busy_window: got %0d bad cycles want 0", bad);
    end
    checks++;
    if (tx_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL busy_release: got ready %b busy %b want 1 0", tx_ready, busy);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (rv_cnt !== n0 + 1 || ss_n_out !== 1'b1 || rv_ack !== GOOD_ACK) begin
      errors++;
      $display("FAIL busy_single_frame: got frames %0d ss_n %b ack %h want 1 1 %h",
               rv_cnt - n0, ss_n_out, rv_ack, GOOD_ACK);
    end
    got = 4'hx;
    if (nib_q.size() != 0) got = nib_q.pop_front();
    checks++;
    if (got !== nib || nib_q.size() != 0) begin
      errors++; $display("FAIL busy_nibble: got %h want %h", got, nib);
    end
  endtask

  task automatic test_reset_mid_frame();
    int t, n0, nq;
    slave_ack = GOOD_ACK;
    wait_ready();
    t = cyc; n0 = rv_cnt; nq = nib_q.size();
    tx_data = 4'hE; tx_valid = 1'b1;
    @(negedge clk); tx_valid = 1'b0;
    // Third rising edge: first at t+1+CLK_DIV, then one per SCLK period.
    while (cyc < t + 1 + CLK_DIV + 2 * 2 * CLK_DIV) @(negedge clk);
    checks++;
    if (sclk_out !== 1'b1 || ss_n_out !== 1'b0) begin
      errors++; $display("FAIL mid_edge3: got sclk %b ss_n %b want 1 0", sclk_out, ss_n_out);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (ss_n_out !== 1'b1 || sclk_out !== 1'b0 || busy !== 1'b0 || mosi_out !== 1'b0 ||
        tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_state: got ss_n %b sclk %b busy %b mosi %b ready %b",
               ss_n_out, sclk_out, busy, mosi_out, tx_ready);
    end
    reset = 1'b0;
    repeat (100) @(negedge clk);
    checks++;
    if (rv_cnt !== n0 || nib_q.size() !== nq || rx_ack !== 8'h00) begin
      errors++;
      $display("FAIL mid_abandon: got rx_valids %0d nibbles %0d ack %h want 0 0 00",
               rv_cnt - n0, nib_q.size() - nq, rx_ack);
    end
    send_frame(4'h5, GOOD_ACK, "post_reset_5");
  endtask

  task automatic test_ack_check();
    send_frame(4'h9, 8'h11, "ack_bad_11");
    send_frame(4'h6, GOOD_ACK, "ack_good_10");
  endtask

  task automatic test_random();
    logic [3:0] nib;
    logic [7:0] ack;
    for (int i = 0; i < 6; i++) begin
      nib = 4'($urandom_range(15, 0));
      ack = ($urandom_range(1, 0) == 0) ? GOOD_ACK : 8'($urandom_range(255, 0));
      send_frame(nib, ack, $sformatf("rand_%0d", i));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid_frame();
    test_ack_check();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
